// File: rtl/acc_regfile_if.sv
// Bus between the sequencer/ALU side and the accumulator register file.
// The master drives the write-back controls; the slave returns architectural state.
interface acc_regfile_if;
    logic [4:0] result;
    logic [2:0] wb_op;
    logic       hold;
    logic [3:0] reg_sel;
    logic [2:0] pair_sel;
    logic [7:0] pair_data;
    logic [3:0] acc;
    logic       carry;
    logic [3:0] regval;
    logic [7:0] pair_val;
    logic       acc_zero;

    modport master (
        output result, wb_op, hold, reg_sel, pair_sel, pair_data,
        input  acc, carry, regval, pair_val, acc_zero
    );

    modport slave (
        input  result, wb_op, hold, reg_sel, pair_sel, pair_data,
        output acc, carry, regval, pair_val, acc_zero
    );
endinterface

// File: rtl/acc_regfile.sv
// Accumulator, carry flag and sixteen 4-bit index registers for the 4-bit core.
// All reads come straight from the flops, so result never reaches an output combinationally.
module acc_regfile (
    input  logic          clock,
    input  logic          reset,
    acc_regfile_if.slave  bus
);
    typedef enum logic [2:0] {
        WB_NONE  = 3'd0,
        WB_ACC   = 3'd1,
        WB_ACC_C = 3'd2,
        WB_REG   = 3'd3,
        WB_XCH   = 3'd4,
        WB_CARRY = 3'd5,
        WB_PAIR  = 3'd6,
        WB_CLB   = 3'd7
    } wb_op_e;

    logic [3:0] acc_q;
    logic       carry_q;
    logic [3:0] regs_q [16];

    logic [3:0] pair_hi_idx;
    logic [3:0] pair_lo_idx;

    assign pair_hi_idx = {bus.pair_sel, 1'b0};
    assign pair_lo_idx = {bus.pair_sel, 1'b1};

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q   <= 4'h0;
            carry_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else if (!bus.hold) begin
            unique case (wb_op_e'(bus.wb_op))
                WB_NONE: ;
                WB_ACC: acc_q <= bus.result[3:0];
                WB_ACC_C: begin
                    acc_q   <= bus.result[3:0];
                    carry_q <= bus.result[4];
                end
                WB_REG: regs_q[bus.reg_sel] <= bus.result[3:0];
                // Both sides use pre-edge values, so the swap needs no temporary.
                WB_XCH: begin
                    acc_q               <= regs_q[bus.reg_sel];
                    regs_q[bus.reg_sel] <= acc_q;
                end
                WB_CARRY: carry_q <= bus.result[4];
                WB_PAIR: begin
                    regs_q[pair_hi_idx] <= bus.pair_data[7:4];
                    regs_q[pair_lo_idx] <= bus.pair_data[3:0];
                end
                WB_CLB: begin
                    acc_q   <= 4'h0;
                    carry_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.acc      = acc_q;
    assign bus.carry    = carry_q;
    assign bus.acc_zero = (acc_q == 4'h0);
    assign bus.regval   = regs_q[bus.reg_sel];
    assign bus.pair_val = {regs_q[pair_hi_idx], regs_q[pair_lo_idx]};
endmodule

// File: doc/acc_regfile.md
# acc_regfile

Architectural state store that sits directly downstream of the 4-bit ALU and also feeds it. It holds the accumulator, the carry flag and the sixteen 4-bit index registers (eight 8-bit pairs). Each cycle it captures the ALU's 5-bit result, or other write sources, according to a write-back opcode from the instruction sequencer. It presents `acc`, `carry` and the selected `regval` back to the ALU operand muxes, and a selected 8-bit register pair to the address path.

## Interface
Parameters:
- none; widths are fixed by the 4-bit datapath (4-bit regs, 16 regs, 5-bit ALU result).

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `result`  in  5  ALU output; `[4]` is carry-out, `[3:0]` is the value.
- `wb_op`  in  3  write-back opcode; encodings below.
- `hold`  in  1  stall; when high, no state changes regardless of `wb_op`.
- `reg_sel`  in  4  index register addressed for `regval` read and REG/XCH write.
- `pair_sel`  in  3  register pair addressed for `pair_val` read and PAIR write.
- `pair_data`  in  8  data for PAIR write.
- `acc`  out  4  accumulator.
- `carry`  out  1  carry flag.
- `regval`  out  4  contents of register `reg_sel`.
- `pair_val`  out  8  `{R[2*pair_sel], R[2*pair_sel+1]}`.
- `acc_zero`  out  1  high when `acc == 0`.

## Operation
- **State:** `acc[3:0]`, `carry`, and `R0..R15[3:0]`. Pair n is R(2n) as the high nibble and R(2n+1) as the low nibble.
- **Reads are combinational** from current state. `regval`, `pair_val`, `acc`, `carry` and `acc_zero` reflect pre-edge values and have no bypass of same-cycle writes.
- **`wb_op` encodings.** All writes occur at the rising edge when `hold=0` and `reset=0`.
  - 0 NONE: no change.
  - 1 ACC: `acc<=result[3:0]`; carry unchanged.
  - 2 ACC_C: `acc<=result[3:0]`, `carry<=result[4]`.
  - 3 REG: `R[reg_sel]<=result[3:0]`.
  - 4 XCH: `acc<=R[reg_sel]` and `R[reg_sel]<=acc`, both simultaneously using old values.
  - 5 CARRY: `carry<=result[4]`; acc unchanged.
  - 6 PAIR: `R[2*pair_sel]<=pair_data[7:4]`, `R[2*pair_sel+1]<=pair_data[3:0]`.
  - 7 CLB: `acc<=0`, `carry<=0`.
- **Single write port per class.** A single `wb_op` per cycle makes REG, XCH and PAIR writes mutually exclusive, so no intra-cycle conflict exists.
- **Unaddressed registers hold their value** on every operation.
- **Priority:** `reset` > `hold` > `wb_op`.

## Timing
- **Reset:** `reset` high at an edge clears `acc=0`, `carry=0` and all `R=0`. This applies even mid-sequence (e.g. between ALU compute and write-back) and discards that cycle's write. After the reset edge: `acc=0`, `carry=0`, `regval=0`, `pair_val=0`, `acc_zero=1`.
- **Write latency:** 1 cycle. A value written at edge k is visible on outputs immediately after edge k. A read in the same cycle as the write returns the old value.
- **Read-modify-write in one cycle.** ALU inputs come from this block's outputs, and the result returns to this block in the same cycle. The datapath `acc -> ALU -> result -> acc` is therefore a single-cycle loop closed only through this block's flops; no combinational path from `result` to any output is permitted.
- **`hold`:** while asserted, all state is frozen for any number of cycles. Outputs still track `reg_sel` and `pair_sel` changes combinationally.
- **Wrap-around:** `result` is already truncated by the ALU. This block stores `[3:0]` and the `[4]` bit verbatim, with no further arithmetic.
- **`pair_sel`:** `pair_sel=7` addresses R14/R15; there is no out-of-range case.

## Test plan
- **Reset:** after any state, assert `reset` for 1 cycle -> `acc=0`, `carry=0`, `acc_zero=1`, and `regval=0` for every `reg_sel`.
- **ACC_C then carry retention:** `result=5'b1_0011`, `wb_op=2` -> `acc=3`, `carry=1`. Then `wb_op=1`, `result=5'b0_1111` -> `acc=F`, `carry` remains 1.
- **PAIR and readback:** `pair_sel=5`, `pair_data=8'hA7`, `wb_op=6` -> `pair_val=A7` with `pair_sel=5`, R10=A, R11=7. `reg_sel=10` -> `regval=A`; all other registers are unchanged.
- **XCH swap:** `acc=4`, R3=9, `reg_sel=3`, `wb_op=4` -> `acc=9`, R3=4. Repeating the XCH restores `acc=4`, R3=9.
- **Hold vs reset priority:**
  - `hold=1`, `wb_op=3`, `result=6`, `reg_sel=2` for 3 cycles -> R2 unchanged.
  - `hold=1` with `reset=1` -> all state cleared.
- **Same-cycle read-before-write:** `reg_sel=0`, `wb_op=3`, `result=5` with R0=2 -> `regval=2` before the edge and 5 after; CLB then gives `acc=0`, `carry=0`, `acc_zero=1`.
